video_out_formatter: RTL and testbench

VIDEO_OUT_FORMATTER -- requirements
Module: video_out_formatter

---
 rtl/video_pkg.sv | 30 +++
 rtl/video_timing_meas.sv | 166 ++++++++++++++++
 rtl/video_out_formatter.sv | 115 +++++++++++
 tb/tb_video_out_formatter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : video_pkg                                          |
// | Description : Shared constants for the video output formatter:   |
// |               measurement width, colour field positions and      |
// |               pipeline depth.                                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package video_pkg;

  // Default width of the line/pixel measurement counters
  localparam int c_max_dim_w  = 12;

  // Colour field positions inside the 32-bit clocked-video word
  localparam int c_chan_w     = 8;
  localparam int c_r_lsb      = 16;
  localparam int c_g_lsb      = 8;
  localparam int c_b_lsb      = 0;

  // Number of registered stages between the video input and the DAC pins
  localparam int c_pipe_depth = 2;

  // Pull one 8-bit colour channel out of a pixel word
  function automatic logic [c_chan_w-1:0] f_chan(input logic [31:0] i_word,
                                                 input int          i_lsb);
    f_chan = i_word[i_lsb +: c_chan_w];
  endfunction

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_timing_meas.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : video_timing_meas                                  |
// | Description : Measures active pixels per line and active lines   |
// |               per frame, counts frames and keeps sticky status   |
// |               (underflow, format change). Works on the stage-1   |
// |               registered datavalid / vsync of the formatter.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module video_timing_meas #(
  parameter int MAX_DIM_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dv,
  input  logic                 i_vs,
  input  logic                 i_underflow,
  input  logic                 i_stat_clear,
  output logic [MAX_DIM_W-1:0] o_meas_width,
  output logic [MAX_DIM_W-1:0] o_meas_height,
  output logic [15:0]          o_frame_cnt,
  output logic                 o_underflow_sticky,
  output logic                 o_fmt_changed
);

  localparam logic [MAX_DIM_W-1:0] c_dim_max = {MAX_DIM_W{1'b1}};

  logic                 r_dv_q;
  logic                 r_vs_q;
  logic                 r_armed;
  logic [MAX_DIM_W-1:0] r_pix_cnt;
  logic [MAX_DIM_W-1:0] r_line_cnt;
  logic [MAX_DIM_W-1:0] r_line_width;
  logic [MAX_DIM_W-1:0] r_meas_w;
  logic [MAX_DIM_W-1:0] r_meas_h;
  logic [15:0]          r_frame_cnt;
  logic                 r_uf_sticky;
  logic                 r_fmt_chg;

  logic                 w_dv_fall;
  logic                 w_vs_rise;
  logic [MAX_DIM_W-1:0] w_line_next;
  logic [MAX_DIM_W-1:0] w_width_next;
  logic                 w_count_frame;
  logic                 w_fmt_diff;

  assign w_dv_fall = r_dv_q & ~i_dv;
  assign w_vs_rise = i_vs & ~r_vs_q;

  // A line ending on the boundary cycle is folded in before the frame is captured
  assign w_line_next  = w_dv_fall ? ((r_line_cnt == c_dim_max) ? r_line_cnt : r_line_cnt + 1'b1)
                                  : r_line_cnt;
  assign w_width_next = w_dv_fall ? r_pix_cnt : r_line_width;

  // Frames with no active lines, or the partial frame before the first boundary, are skipped
  assign w_count_frame = w_vs_rise & r_armed & (w_line_next != '0);

  // A zero previous value means "never measured", so it cannot flag a change
  assign w_fmt_diff = ((r_meas_w != '0) && (w_width_next != r_meas_w)) ||
                      ((r_meas_h != '0) && (w_line_next  != r_meas_h));

  // One-cycle history of datavalid and vsync for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv_q <= 1'b0;
      r_vs_q <= 1'b0;
    end else begin
      r_dv_q <= i_dv;
      r_vs_q <= i_vs;
    end
  end

  // Saturating pixel counter, restarted at the end of each active line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (i_dv) begin
      if (r_pix_cnt != c_dim_max) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end else if (w_dv_fall) begin
      r_pix_cnt <= '0;
    end
  end

  // Latch the pixel count of the line that just ended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_width <= '0;
    end else if (w_dv_fall) begin
      r_line_width <= r_pix_cnt;
    end
  end

  // Saturating line counter, restarted at every frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= '0;
    end else if (w_vs_rise) begin
      r_line_cnt <= '0;
    end else begin
      r_line_cnt <= w_line_next;
    end
  end

  // Arm counting at the first boundary so a frame cut by reset is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (w_vs_rise) begin
      r_armed <= 1'b1;
    end
  end

  // Publish the dimensions of each counted frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_w <= '0;
      r_meas_h <= '0;
    end else if (w_count_frame) begin
      r_meas_w <= w_width_next;
      r_meas_h <= w_line_next;
    end
  end

  // Frame counter; a frame counted on the clear cycle leaves it at one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_count_frame) begin
      r_frame_cnt <= i_stat_clear ? 16'd1 : r_frame_cnt + 16'd1;
    end else if (i_stat_clear) begin
      r_frame_cnt <= '0;
    end
  end

  // Sticky format-change flag; a set on the clear cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmt_chg <= 1'b0;
    end else if (w_count_frame && w_fmt_diff) begin
      r_fmt_chg <= 1'b1;
    end else if (i_stat_clear) begin
      r_fmt_chg <= 1'b0;
    end
  end

  // Sticky underflow flag; a pulse on the clear cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uf_sticky <= 1'b0;
    end else if (i_underflow) begin
      r_uf_sticky <= 1'b1;
    end else if (i_stat_clear) begin
      r_uf_sticky <= 1'b0;
    end
  end

  assign o_meas_width       = r_meas_w;
  assign o_meas_height      = r_meas_h;
  assign o_frame_cnt        = r_frame_cnt;
  assign o_underflow_sticky = r_uf_sticky;
  assign o_fmt_changed      = r_fmt_chg;

endmodule : video_timing_meas
`default_nettype wire

// File: rtl/video_out_formatter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : video_out_formatter                                |
// | Description : Two-stage register pipeline from the clocked-video |
// |               output to a VGA DAC: RGB split, blanking, sync     |
// |               polarity, plus timing measurement and status.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module video_out_formatter
  import video_pkg::*;
#(
  parameter bit H_SYNC_NEG = 1'b1,
  parameter bit V_SYNC_NEG = 1'b1,
  parameter int MAX_DIM_W  = c_max_dim_w
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [31:0]          vid_data,
  input  logic                 vid_datavalid,
  input  logic                 vid_h_sync,
  input  logic                 vid_v_sync,
  input  logic                 vid_underflow,
  input  logic                 stat_clear,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic [MAX_DIM_W-1:0] meas_width,
  output logic [MAX_DIM_W-1:0] meas_height,
  output logic [15:0]          frame_cnt,
  output logic                 underflow_sticky,
  output logic                 fmt_changed
);

  // Stage 1: raw capture of the clocked-video signals
  logic [c_chan_w-1:0] r_s1_r;
  logic [c_chan_w-1:0] r_s1_g;
  logic [c_chan_w-1:0] r_s1_b;
  logic                r_s1_dv;
  logic                r_s1_hs;
  logic                r_s1_vs;

  // Stage 2: DAC-facing output registers
  logic [c_chan_w-1:0] r_s2_r;
  logic [c_chan_w-1:0] r_s2_g;
  logic [c_chan_w-1:0] r_s2_b;
  logic                r_s2_blank_n;
  logic                r_s2_hs;
  logic                r_s2_vs;

  // Stage 1 capture of pixel fields, qualifier and active-high syncs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1_r  <= '0;
      r_s1_g  <= '0;
      r_s1_b  <= '0;
      r_s1_dv <= 1'b0;
      r_s1_hs <= 1'b0;
      r_s1_vs <= 1'b0;
    end else begin
      r_s1_r  <= f_chan(vid_data, c_r_lsb);
      r_s1_g  <= f_chan(vid_data, c_g_lsb);
      r_s1_b  <= f_chan(vid_data, c_b_lsb);
      r_s1_dv <= vid_datavalid;
      r_s1_hs <= vid_h_sync;
      r_s1_vs <= vid_v_sync;
    end
  end

  // Stage 2: blank colour outside active video and apply sync polarity only here
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s2_r       <= '0;
      r_s2_g       <= '0;
      r_s2_b       <= '0;
      r_s2_blank_n <= 1'b0;
      r_s2_hs      <= H_SYNC_NEG;
      r_s2_vs      <= V_SYNC_NEG;
    end else begin
      r_s2_r       <= r_s1_dv ? r_s1_r : '0;
      r_s2_g       <= r_s1_dv ? r_s1_g : '0;
      r_s2_b       <= r_s1_dv ? r_s1_b : '0;
      r_s2_blank_n <= r_s1_dv;
      r_s2_hs      <= r_s1_hs ^ H_SYNC_NEG;
      r_s2_vs      <= r_s1_vs ^ V_SYNC_NEG;
    end
  end

  assign vga_r       = r_s2_r;
  assign vga_g       = r_s2_g;
  assign vga_b       = r_s2_b;
  assign vga_blank_n = r_s2_blank_n;
  assign vga_hs      = r_s2_hs;
  assign vga_vs      = r_s2_vs;

  video_timing_meas #(
    .MAX_DIM_W (MAX_DIM_W)
  ) u_meas (
    .clk                (clk_clk),
    .rst_n              (reset_reset_n),
    .i_dv               (r_s1_dv),
    .i_vs               (r_s1_vs),
    .i_underflow        (vid_underflow),
    .i_stat_clear       (stat_clear),
    .o_meas_width       (meas_width),
    .o_meas_height      (meas_height),
    .o_frame_cnt        (frame_cnt),
    .o_underflow_sticky (underflow_sticky),
    .o_fmt_changed      (fmt_changed)
  );

endmodule : video_out_formatter
`default_nettype wire

// File: tb/tb_video_out_formatter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_video_out_formatter                             |
// | Description : Self-checking bench for video_out_formatter:       |
// |               pipeline vector table plus directed frame, status  |
// |               and reset sequences.                               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_video_out_formatter;

  localparam int c_w = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    vid_data;
  logic           vid_dv;
  logic           vid_hs;
  logic           vid_vs;
  logic           vid_uf;
  logic           clr;
  logic [7:0]     vga_r;
  logic [7:0]     vga_g;
  logic [7:0]     vga_b;
  logic           vga_hs;
  logic           vga_vs;
  logic           vga_blank_n;
  logic [c_w-1:0] meas_w;
  logic [c_w-1:0] meas_h;
  logic [15:0]    frame_cnt;
  logic           uf_sticky;
  logic           fmt_chg;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        dv;
    logic [31:0] data;
    logic        hs;
    logic        vs;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
    logic        eblank_n;
    logic        ehs;
    logic        evs;
  } vec_t;

  vec_t vecs [6];

  video_out_formatter #(
    .H_SYNC_NEG (1'b1),
    .V_SYNC_NEG (1'b1),
    .MAX_DIM_W  (c_w)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .vid_data         (vid_data),
    .vid_datavalid    (vid_dv),
    .vid_h_sync       (vid_hs),
    .vid_v_sync       (vid_vs),
    .vid_underflow    (vid_uf),
    .stat_clear       (clr),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hs           (vga_hs),
    .vga_vs           (vga_vs),
    .vga_blank_n      (vga_blank_n),
    .meas_width       (meas_w),
    .meas_height      (meas_h),
    .frame_cnt        (frame_cnt),
    .underflow_sticky (uf_sticky),
    .fmt_changed      (fmt_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    vid_dv   = 1'b0;
    vid_data = 32'h0;
    vid_hs   = 1'b0;
    vid_vs   = 1'b0;
    vid_uf   = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send_line(input int w);
    vid_dv   = 1'b1;
    vid_data = 32'h0080_4020;
    repeat (w) tick();
    vid_dv   = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_frame(input int w, input int h);
    for (int l = 0; l < h; l++) send_line(w);
  endtask

  // clear_on_edge drives stat_clear onto the same edge the boundary is processed
  task automatic send_vsync(input bit clear_on_edge);
    vid_vs = 1'b1;
    tick();
    if (clear_on_edge) clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    vid_vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic chk_meas(input string tag, input int w, input int h, input int fc, input bit chg);
    chk({tag, ".meas_width"},  32'(meas_w),    32'(w));
    chk({tag, ".meas_height"}, 32'(meas_h),    32'(h));
    chk({tag, ".frame_cnt"},   32'(frame_cnt), 32'(fc));
    chk({tag, ".fmt_changed"}, 32'(fmt_chg),   32'(chg));
  endtask

  initial begin
    // dv, data, hs, vs -> r, g, b, blank_n, hs, vs (both syncs active-low at the pins)
    vecs[0] = '{1'b1, 32'h00AA_BBCC, 1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 32'h00FF_FFFF, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'hFF10_2030, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0012_3456, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'hA5FF_FFFF, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};

    // Reset held with active white pixels on the input
    drive_idle();
    rst_n    = 1'b0;
    vid_dv   = 1'b1;
    vid_data = 32'h00FF_FFFF;
    repeat (3) tick();
    chk("rst.r",       32'(vga_r), 32'h0);
    chk("rst.g",       32'(vga_g), 32'h0);
    chk("rst.b",       32'(vga_b), 32'h0);
    chk("rst.blank_n", 32'(vga_blank_n), 32'h0);
    chk("rst.hs",      32'(vga_hs), 32'h1);
    chk("rst.vs",      32'(vga_vs), 32'h1);
    chk("rst.sticky",  32'(uf_sticky), 32'h0);
    chk_meas("rst", 0, 0, 0, 1'b0);

    drive_idle();
    rst_n = 1'b1;
    repeat (3) tick();

    // Table: each output sample reflects the vector applied two edges earlier
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        vid_dv   = vecs[i].dv;
        vid_data = vecs[i].data;
        vid_hs   = vecs[i].hs;
        vid_vs   = vecs[i].vs;
      end else begin
        drive_idle();
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("vec%0d.r", i-1),       32'(vga_r),       32'(vecs[i-1].er));
        chk($sformatf("vec%0d.g", i-1),       32'(vga_g),       32'(vecs[i-1].eg));
        chk($sformatf("vec%0d.b", i-1),       32'(vga_b),       32'(vecs[i-1].eb));
        chk($sformatf("vec%0d.blank_n", i-1), 32'(vga_blank_n), 32'(vecs[i-1].eblank_n));
        chk($sformatf("vec%0d.hs", i-1),      32'(vga_hs),      32'(vecs[i-1].ehs));
        chk($sformatf("vec%0d.vs", i-1),      32'(vga_vs),      32'(vecs[i-1].evs));
      end
    end

    // Single-cycle pixel appears exactly two edges later and nowhere else
    drive_idle();
    repeat (3) tick();
    vid_dv   = 1'b1;
    vid_data = 32'h1234_5678;
    tick();
    chk("lat.n1.blank_n", 32'(vga_blank_n), 32'h0);
    drive_idle();
    tick();
    chk("lat.n2.r",       32'(vga_r), 32'h34);
    chk("lat.n2.g",       32'(vga_g), 32'h56);
    chk("lat.n2.b",       32'(vga_b), 32'h78);
    chk("lat.n2.blank_n", 32'(vga_blank_n), 32'h1);
    tick();
    chk("lat.n3.blank_n", 32'(vga_blank_n), 32'h0);
    chk("lat.n3.r",       32'(vga_r), 32'h0);

    // Asynchronous reset in the middle of active video
    vid_dv   = 1'b1;
    vid_data = 32'h00FF_FFFF;
    repeat (3) tick();
    chk("arst.pre.blank_n", 32'(vga_blank_n), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.blank_n", 32'(vga_blank_n), 32'h0);
    chk("arst.r",       32'(vga_r), 32'h0);
    repeat (2) tick();
    drive_idle();
    rst_n = 1'b1;
    tick();

    // Partial frame since reset is discarded at the first boundary
    send_frame(640, 6);
    send_vsync(1'b0);
    chk_meas("discard", 0, 0, 0, 1'b0);

    send_frame(640, 6);
    send_vsync(1'b0);
    chk_meas("f1", 640, 6, 1, 1'b0);

    send_frame(640, 6);
    send_vsync(1'b0);
    chk_meas("f2", 640, 6, 2, 1'b0);

    // Format change
    send_frame(800, 7);
    send_vsync(1'b0);
    chk_meas("fmt", 800, 7, 3, 1'b1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk_meas("clr", 800, 7, 0, 1'b0);

    send_frame(800, 7);
    send_vsync(1'b0);
    chk_meas("same", 800, 7, 1, 1'b0);

    // Empty frame holds everything
    send_vsync(1'b0);
    chk_meas("empty", 800, 7, 1, 1'b0);

    // Over-long line saturates the pixel counter
    send_line(5000);
    send_vsync(1'b0);
    chk_meas("sat", 4095, 1, 2, 1'b1);

    // Clear coincident with a counted frame that also changes format
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    send_frame(640, 6);
    send_vsync(1'b1);
    chk_meas("clr_cnt", 640, 6, 1, 1'b1);

    // Clear coincident with an empty frame
    send_vsync(1'b1);
    chk_meas("clr_empty", 640, 6, 0, 1'b0);

    // Last datavalid fall lands on the boundary cycle
    send_frame(640, 2);
    vid_dv = 1'b1;
    repeat (640) tick();
    vid_dv = 1'b0;
    vid_vs = 1'b1;
    repeat (3) tick();
    vid_vs = 1'b0;
    repeat (4) tick();
    chk_meas("fall_edge", 640, 3, 1, 1'b1);

    // Underflow stickiness and clear priority
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("uf.idle", 32'(uf_sticky), 32'h0);
    vid_uf = 1'b1;
    tick();
    vid_uf = 1'b0;
    repeat (5) tick();
    chk("uf.held", 32'(uf_sticky), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("uf.cleared", 32'(uf_sticky), 32'h0);
    vid_uf = 1'b1;
    tick();
    vid_uf = 1'b0;
    tick();
    clr    = 1'b1;
    vid_uf = 1'b1;
    tick();
    clr    = 1'b0;
    vid_uf = 1'b0;
    repeat (2) tick();
    chk("uf.set_wins", 32'(uf_sticky), 32'h1);
    chk_meas("final", 640, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_video_out_formatter
`default_nettype wire
